// File: rtl/conv2d_stream_engine.sv
// Multi-filter 2D convolution engine: host-loaded image/filter memories, one MAC per
// cycle, optional ReLU and saturation, results streamed on a valid/ready interface.
module conv2d_stream_engine #(
    parameter int unsigned IMG_SIZE    = 6,
    parameter int unsigned FILT_SIZE   = 3,
    parameter int unsigned NUM_FILTERS = 3,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ACC_W       = 20,
    parameter int unsigned OUT_W       = 16,
    localparam int unsigned IA         = $clog2(IMG_SIZE * IMG_SIZE),
    localparam int unsigned FA         = $clog2(NUM_FILTERS * FILT_SIZE * FILT_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     img_wr_en,
    input  logic [IA-1:0]            img_wr_addr,
    input  logic signed [DATA_W-1:0] img_wr_data,
    input  logic                     flt_wr_en,
    input  logic [FA-1:0]            flt_wr_addr,
    input  logic signed [DATA_W-1:0] flt_wr_data,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic                     sat_en,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [15:0]              out_idx
);

    localparam int unsigned R         = (IMG_SIZE - FILT_SIZE) / STRIDE + 1;
    localparam int unsigned IMG_DEPTH = IMG_SIZE * IMG_SIZE;
    localparam int unsigned FLT_DEPTH = NUM_FILTERS * FILT_SIZE * FILT_SIZE;
    localparam int unsigned TOTAL     = NUM_FILTERS * R * R;
    localparam int unsigned CW        = 16;
    localparam int unsigned PW        = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}});

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUTPUT, S_DONE} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] img_mem [IMG_DEPTH];
    logic signed [DATA_W-1:0] flt_mem [FLT_DEPTH];

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [PW-1:0]    prod;
    logic [IA-1:0]           pix_addr;
    logic [FA-1:0]           tap_addr;
    logic [CW-1:0]           tap_r, tap_c, col_cnt, row_cnt, flt_cnt, idx_cnt;
    logic                    relu_q, sat_q;
    logic                    tap_last, hs, idx_last;

    assign tap_last = (tap_r == CW'(FILT_SIZE - 1)) && (tap_c == CW'(FILT_SIZE - 1));
    assign hs       = out_valid && out_ready;
    assign idx_last = (idx_cnt == CW'(TOTAL - 1));

    // ReLU first, then saturate or truncate to the output width
    function automatic logic signed [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                          input logic relu,
                                                          input logic sat);
        logic signed [ACC_W-1:0] v;
        v = (relu && a[ACC_W-1]) ? '0 : a;
        if (sat && (v > SAT_MAX)) v = SAT_MAX;
        if (sat && (v < SAT_MIN)) v = SAT_MIN;
        return v[OUT_W-1:0];
    endfunction

    // Host write ports; memories are frozen outside IDLE
    always_ff @(posedge clk) begin
        if (state == S_IDLE && img_wr_en && (32'(img_wr_addr) < IMG_DEPTH))
            img_mem[img_wr_addr] <= img_wr_data;
        if (state == S_IDLE && flt_wr_en && (32'(flt_wr_addr) < FLT_DEPTH))
            flt_mem[flt_wr_addr] <= flt_wr_data;
    end

    // Window/tap address generation and the MAC adder
    always_comb begin
        pix_addr = IA'((32'(row_cnt) * STRIDE + 32'(tap_r)) * IMG_SIZE
                       + 32'(col_cnt) * STRIDE + 32'(tap_c));
        tap_addr = FA'(32'(flt_cnt) * FILT_SIZE * FILT_SIZE
                       + 32'(tap_r) * FILT_SIZE + 32'(tap_c));
        prod     = img_mem[pix_addr] * flt_mem[tap_addr];
        mac_sum  = acc + ACC_W'(prod);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start)    state_nxt = S_COMPUTE;
            S_COMPUTE: if (tap_last) state_nxt = S_OUTPUT;
            S_OUTPUT:  if (hs)       state_nxt = idx_last ? S_DONE : S_COMPUTE;
            S_DONE:                  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            acc       <= '0;
            tap_r     <= '0;
            tap_c     <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            flt_cnt   <= '0;
            idx_cnt   <= '0;
            relu_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        relu_q  <= relu_en;
                        sat_q   <= sat_en;
                        busy    <= 1'b1;
                        acc     <= '0;
                        tap_r   <= '0;
                        tap_c   <= '0;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        flt_cnt <= '0;
                        idx_cnt <= '0;
                    end
                end
                S_COMPUTE: begin
                    if (tap_last) begin
                        out_data  <= post_proc(mac_sum, relu_q, sat_q);
                        out_idx   <= idx_cnt;
                        out_valid <= 1'b1;
                    end else begin
                        acc <= mac_sum;
                        if (tap_c == CW'(FILT_SIZE - 1)) begin
                            tap_c <= '0;
                            tap_r <= tap_r + 1'b1;
                        end else begin
                            tap_c <= tap_c + 1'b1;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        tap_r     <= '0;
                        tap_c     <= '0;
                        idx_cnt   <= idx_cnt + 1'b1;
                        if (col_cnt == CW'(R - 1)) begin
                            col_cnt <= '0;
                            if (row_cnt == CW'(R - 1)) begin
                                row_cnt <= '0;
                                flt_cnt <= flt_cnt + 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: default instance plus a stride-2, 2x2 instance.
module tb_conv2d_stream_engine;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic              img_wr_en, flt_wr_en, start, relu_en, sat_en, out_ready;
    logic [5:0]        img_wr_addr;
    logic [4:0]        flt_wr_addr;
    logic signed [7:0] img_wr_data, flt_wr_data;
    logic              busy, done, out_valid;
    logic [15:0]       out_data, out_idx;

    logic              s_flt_wr_en, s_start;
    logic [1:0]        s_flt_wr_addr;
    logic signed [7:0] s_flt_wr_data;
    logic              s_busy, s_done, s_out_valid;
    logic [15:0]       s_out_data, s_out_idx;

    conv2d_stream_engine u_dut (
        .clk(clk), .reset_n(reset_n),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
        .flt_wr_en(flt_wr_en), .flt_wr_addr(flt_wr_addr), .flt_wr_data(flt_wr_data),
        .start(start), .relu_en(relu_en), .sat_en(sat_en),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx)
    );

    conv2d_stream_engine #(.FILT_SIZE(2), .NUM_FILTERS(1), .STRIDE(2)) u_s2 (
        .clk(clk), .reset_n(reset_n),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
        .flt_wr_en(s_flt_wr_en), .flt_wr_addr(s_flt_wr_addr), .flt_wr_data(s_flt_wr_data),
        .start(s_start), .relu_en(1'b0), .sat_en(1'b0),
        .busy(s_busy), .done(s_done), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_data(s_out_data), .out_idx(s_out_idx)
    );

    int vec  = 0;
    int errs = 0;
    int img [36];
    int flt [27];
    bit m_relu, m_sat;

    // Reference result for flat index idx of the default (N=6,K=3,F=3,S=1) engine
    function automatic logic [15:0] exp_val(input int idx);
        int f, r, c, acc;
        f = idx / 16; r = (idx % 16) / 4; c = idx % 4; acc = 0;
        for (int tr = 0; tr < 3; tr++)
            for (int tc = 0; tc < 3; tc++)
                acc += img[(r + tr) * 6 + c + tc] * flt[f * 9 + tr * 3 + tc];
        if (m_relu && acc < 0) acc = 0;
        if (m_sat && acc > 32767) acc = 32767;
        if (m_sat && acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 36; i++) begin
            @(negedge clk); img_wr_en = 1'b1; img_wr_addr = 6'(i); img_wr_data = 8'(img[i]);
        end
        @(negedge clk); img_wr_en = 1'b0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk); flt_wr_en = 1'b1; flt_wr_addr = 5'(i); flt_wr_data = 8'(flt[i]);
        end
        @(negedge clk); flt_wr_en = 1'b0;
    endtask

    // Full run: checks order, values, stall stability, done timing and busy
    task automatic run_check(input string name, input bit rand_rdy, input bit chk_time,
                             input bit disturb, input bit wr_with_start);
        int t, got;
        bit seen_done, stalled;
        logic [15:0] held_d, held_i;
        @(negedge clk);
        relu_en = m_relu; sat_en = m_sat; start = 1'b1; out_ready = 1'b1;
        if (wr_with_start) begin
            img_wr_en = 1'b1; img_wr_addr = 6'd35; img_wr_data = 8'(img[35]);
        end
        t = -1; got = 0; seen_done = 0; stalled = 0; held_d = '0; held_i = '0;
        while (!seen_done && t < 20000) begin
            @(negedge clk); t++; start = 1'b0;
            if (disturb && t == 30) begin
                start = 1'b1; img_wr_en = 1'b1; img_wr_addr = 6'd14; img_wr_data = 8'sh55;
            end else begin
                img_wr_en = 1'b0;
            end
            if (t == 0) begin
                vec++;
                if (busy !== 1'b1) begin errs++; $display("FAIL %s busy_after_start got=%b want=1", name, busy); end
            end
            if (stalled) begin
                vec++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_idx !== held_i) begin
                    errs++;
                    $display("FAIL %s stall_hold t=%0d got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                             name, t, out_valid, out_data, out_idx, held_d, held_i);
                end
            end
            out_ready = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
            if (out_valid && out_ready) begin
                vec += 2;
                if (out_idx !== 16'(got)) begin
                    errs++; $display("FAIL %s idx got=%0d want=%0d", name, out_idx, got);
                end
                if (out_data !== exp_val(got)) begin
                    errs++; $display("FAIL %s data idx=%0d got=%h want=%h", name, got, out_data, exp_val(got));
                end
                if (chk_time && got == 0) begin
                    vec++;
                    if (t != 9) begin errs++; $display("FAIL %s first_valid_cycle got=%0d want=9", name, t); end
                end
                got++; stalled = 0;
            end else begin
                stalled = out_valid; held_d = out_data; held_i = out_idx;
            end
            if (done) begin
                seen_done = 1; vec += 2;
                if (got != 48 || busy !== 1'b0) begin
                    errs++; $display("FAIL %s done_state results=%0d busy=%b want 48/0", name, got, busy);
                end
                if (chk_time && t != 481) begin
                    errs++; $display("FAIL %s done_cycle got=%0d want=481", name, t);
                end
            end
        end
        out_ready = 1'b1; img_wr_en = 1'b0;
        vec++;
        if (!seen_done) begin errs++; $display("FAIL %s timeout results=%0d want 48", name, got); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        vec += 5;
        if (busy !== 1'b0)      begin errs++; $display("FAIL reset busy got=%b want=0", busy); end
        if (done !== 1'b0)      begin errs++; $display("FAIL reset done got=%b want=0", done); end
        if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
        if (out_data !== 16'h0) begin errs++; $display("FAIL reset out_data got=%h want=0", out_data); end
        if (out_idx !== 16'h0)  begin errs++; $display("FAIL reset out_idx got=%0d want=0", out_idx); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ones();
        foreach (img[i]) img[i] = 1;
        foreach (flt[i]) flt[i] = 1;
        m_relu = 0; m_sat = 1;
        load_mem();
        // Out-of-range writes must not alias onto real entries
        @(negedge clk); img_wr_en = 1'b1; img_wr_addr = 6'd40; img_wr_data = 8'sd99;
        flt_wr_en = 1'b1; flt_wr_addr = 5'd30; flt_wr_data = 8'sd99;
        @(negedge clk); img_wr_en = 1'b0; flt_wr_en = 1'b0;
        run_check("ones", 0, 1, 0, 0);
    endtask

    task automatic test_ramp();
        foreach (img[i]) img[i] = i;
        foreach (flt[i]) flt[i] = 0;
        flt[4] = 1;
        for (int i = 9; i < 18; i++) flt[i] = 1;
        flt[18] = 2; flt[26] = -1;
        img[35] = 0;
        load_mem();
        img[35] = 35;
        m_relu = 0; m_sat = 1;
        run_check("ramp", 0, 1, 0, 1);
        vec += 2;
        if (exp_val(0) !== 16'd7)   begin errs++; $display("FAIL ramp_ref idx0 got=%0d want=7", exp_val(0)); end
        if (exp_val(15) !== 16'd28) begin errs++; $display("FAIL ramp_ref idx15 got=%0d want=28", exp_val(15)); end
        m_relu = 1;
        run_check("ramp_relu", 0, 1, 0, 0);
    endtask

    task automatic test_saturation();
        foreach (img[i]) img[i] = 127;
        foreach (flt[i]) flt[i] = -128;
        load_mem();
        m_relu = 0; m_sat = 1;
        run_check("sat", 0, 0, 0, 0);
        m_relu = 1; m_sat = 1;
        run_check("sat_relu", 0, 0, 0, 0);
        m_relu = 0; m_sat = 0;
        run_check("trunc", 0, 0, 0, 0);
        vec++;
        if (exp_val(0) !== 16'hC480) begin errs++; $display("FAIL trunc_ref got=%h want=c480", exp_val(0)); end
    endtask

    task automatic test_back_to_back();
        foreach (img[i]) img[i] = i;
        for (int i = 0; i < 27; i++) flt[i] = (i % 3) - 1;
        load_mem();
        m_relu = 0; m_sat = 1;
        run_check("backpressure", 1, 0, 1, 0);
    endtask

    task automatic test_reset_midrun();
        int t;
        @(negedge clk); start = 1'b1; relu_en = 1'b0; sat_en = 1'b1; out_ready = 1'b1;
        t = -1;
        while (t < 53) begin @(negedge clk); t++; start = 1'b0; end
        vec++;
        if (out_idx !== 16'd4 || busy !== 1'b1) begin
            errs++; $display("FAIL midrun_pre idx=%0d busy=%b want 4/1", out_idx, busy);
        end
        reset_n = 1'b0;
        #1;
        vec += 3;
        if (busy !== 1'b0)      begin errs++; $display("FAIL midrun_reset busy got=%b want=0", busy); end
        if (out_valid !== 1'b0) begin errs++; $display("FAIL midrun_reset out_valid got=%b want=0", out_valid); end
        if (out_idx !== 16'h0)  begin errs++; $display("FAIL midrun_reset out_idx got=%0d want=0", out_idx); end
        @(negedge clk); reset_n = 1'b1;
        run_check("rerun", 0, 1, 0, 0);
    endtask

    task automatic test_stride();
        int t, got, a;
        bit seen;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk); img_wr_en = 1'b1; img_wr_addr = 6'(i); img_wr_data = 8'(i);
        end
        @(negedge clk); img_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); s_flt_wr_en = 1'b1; s_flt_wr_addr = 2'(i); s_flt_wr_data = 8'sd1;
        end
        @(negedge clk); s_flt_wr_en = 1'b0; s_start = 1'b1;
        t = -1; got = 0; seen = 0;
        while (!seen && t < 2000) begin
            @(negedge clk); t++; s_start = 1'b0;
            if (s_out_valid) begin
                a = 12 * (got / 3) + 2 * (got % 3);
                vec += 2;
                if (s_out_idx !== 16'(got)) begin
                    errs++; $display("FAIL stride idx got=%0d want=%0d", s_out_idx, got);
                end
                if (s_out_data !== 16'(4 * a + 14)) begin
                    errs++; $display("FAIL stride data idx=%0d got=%0d want=%0d", got, s_out_data, 4 * a + 14);
                end
                got++;
            end
            if (s_done) begin
                seen = 1; vec++;
                if (t != 46 || got != 9) begin
                    errs++; $display("FAIL stride done cycle=%0d results=%0d want 46/9", t, got);
                end
            end
        end
        vec++;
        if (!seen) begin errs++; $display("FAIL stride timeout results=%0d want 9", got); end
    endtask

    initial begin
        img_wr_en = 0; img_wr_addr = '0; img_wr_data = '0;
        flt_wr_en = 0; flt_wr_addr = '0; flt_wr_data = '0;
        start = 0; relu_en = 0; sat_en = 0; out_ready = 1;
        s_flt_wr_en = 0; s_flt_wr_addr = '0; s_flt_wr_data = '0; s_start = 0;
        test_reset();
        test_ones();
        test_ramp();
        test_saturation();
        test_back_to_back();
        test_reset_midrun();
        test_stride();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
